div_restoring_seq: RTL

- Sequential restoring divider: the inverse of the team's adder/multiplier datapath.
- Computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock, using trial subtraction.
- Sits beside the MULT blocks as the arithmetic unit for division.
- start/done handshake; results held until the next accepted start.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 26 ++
 rtl/div_restoring_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider: FSM encodings,
// default operand width and the quotient reported for a zero divisor.
package div_pkg;

  localparam int DIV_DEFAULT_WIDTH = 4;

  typedef logic [1:0] divState_t;

  localparam divState_t ST_IDLE = 2'd0;
  localparam divState_t ST_RUN  = 2'd1;
  localparam divState_t ST_DONE = 2'd2;

  // Sliced down to the instance width; wide enough for any WIDTH up to 64.
  localparam logic [63:0] DIV_ZERO_QUOTIENT = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor at WIDTH+1 bits, keep or restore.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   partial_i,
  input  logic             dividendBit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   partial_o,
  output logic             quotBit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] divisorInv;
  logic [WIDTH:0] trial;

  assign shifted    = {partial_i[WIDTH-1:0], dividendBit_i};
  assign divisorInv = ~{1'b0, divisor_i};
  assign trial      = shifted + divisorInv + {{WIDTH{1'b0}}, 1'b1};

  // A set bit shifted out of the top means the shifted value already exceeds
  // any divisor, so the subtraction must succeed.
  assign quotBit_o = partial_i[WIDTH] | ~trial[WIDTH];
  assign partial_o = quotBit_o ? trial : shifted;

endmodule

// File: rtl/div_restoring_seq.sv
// Sequential restoring divider, one quotient bit per clock with a start/done
// handshake. Define DIV_SIGNED_EN for two's-complement operands and results.
module div_restoring_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             divByZero_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  divState_t        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH:0]   partialRem_q, partialRem_d;
  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             divByZero_q, divByZero_d;

  logic [WIDTH:0]   stepPartial;
  logic             stepBit;
  logic [WIDTH-1:0] nextQuot;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] magDividend;
  logic [WIDTH-1:0] magDivisor;
  logic [WIDTH-1:0] finalQuot;
  logic [WIDTH-1:0] finalRem;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .partial_i    (partialRem_q),
    .dividendBit_i(shiftReg_q[WIDTH-1]),
    .divisor_i    (divisor_q),
    .partial_o    (stepPartial),
    .quotBit_o    (stepBit)
  );

  // The dividend register doubles as the quotient register as bits shift in.
  assign nextQuot = {shiftReg_q[WIDTH-2:0], stepBit};
  assign nextRem  = stepPartial[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
  logic negQuot_q, negQuot_d;
  logic negRem_q, negRem_d;

  assign magDividend = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
  assign magDivisor  = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
  assign finalQuot   = negQuot_q ? -nextQuot : nextQuot;
  assign finalRem    = negRem_q  ? -nextRem  : nextRem;
`else
  assign magDividend = dividend_i;
  assign magDivisor  = divisor_i;
  assign finalQuot   = nextQuot;
  assign finalRem    = nextRem;
`endif

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    partialRem_d = partialRem_q;
    shiftReg_d   = shiftReg_q;
    divisor_d    = divisor_q;
    quotient_d   = quotient_q;
    remainder_d  = remainder_q;
    divByZero_d  = divByZero_q;
`ifdef DIV_SIGNED_EN
    negQuot_d    = negQuot_q;
    negRem_d     = negRem_q;
`endif

    case (state_q)
      ST_RUN: begin
        partialRem_d = stepPartial;
        shiftReg_d   = nextQuot;
        count_d      = count_q + CNT_W'(1);
        if (count_q == LAST_COUNT) begin
          state_d     = ST_DONE;
          quotient_d  = finalQuot;
          remainder_d = finalRem;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; start is ignored in RUN.
        state_d = ST_IDLE;
        if (start_i) begin
          if (divisor_i == '0) begin
            state_d     = ST_DONE;
            quotient_d  = DIV_ZERO_QUOTIENT[WIDTH-1:0];
            remainder_d = dividend_i;
            divByZero_d = 1'b1;
          end else begin
            state_d      = ST_RUN;
            partialRem_d = '0;
            shiftReg_d   = magDividend;
            divisor_d    = magDivisor;
            count_d      = '0;
            divByZero_d  = 1'b0;
`ifdef DIV_SIGNED_EN
            negQuot_d    = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
            negRem_d     = dividend_i[WIDTH-1];
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      partialRem_q <= '0;
      shiftReg_q   <= '0;
      divisor_q    <= '0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      divByZero_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      negQuot_q    <= 1'b0;
      negRem_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      partialRem_q <= partialRem_d;
      shiftReg_q   <= shiftReg_d;
      divisor_q    <= divisor_d;
      quotient_q   <= quotient_d;
      remainder_q  <= remainder_d;
      divByZero_q  <= divByZero_d;
`ifdef DIV_SIGNED_EN
      negQuot_q    <= negQuot_d;
      negRem_q     <= negRem_d;
`endif
    end
  end

  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_DONE);
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign divByZero_o = divByZero_q;

endmodule
